// File: rtl/clause_vote_accum.sv
// Purpose : checks chunked TA-include/literal beats per clause, ANDs the chunk results
//           into one clause bit, and adds polarity-signed votes into a clamped class sum.
// Latency : clause_out_valid is high 1 cycle after a clause's last beat. class_sum and
//           result_valid are visible 1 cycle after the last beat of the last clause.
// Backpr. : stop_flag holds the upstream counter outside ACCUM. The result is held in
//           DONE until result_valid && result_ready. Out-of-order beats are dropped and
//           set the sticky seq_err.
//
// Ports:
//   clk, rst_flag_n             clock, asynchronous active-low reset
//   start                       one-cycle pulse; clears all pass state and enters ACCUM
//   valid_in, clause_idx,       input beat: position in the pass, plus the TA include
//   chunk_idx, ta_chunk,          bits and the literal bits for that chunk
//   lit_chunk
//   stop_flag                   hold request to the counter (1 outside ACCUM)
//   clause_out_valid/_out/_idx  per-clause result strobe, clause bit and clause index
//   class_sum, result_valid,    clamped signed sum, with a valid/ready handshake
//   result_ready
//   busy                        high while in ACCUM
//   seq_err                     sticky flag for an out-of-order beat

module clause_vote_accum #(
  parameter int CLAUSES     = 2000,
  parameter int LA_CHUNKS   = 49,
  parameter int CHUNK_WIDTH = 32,
  parameter int SUM_WIDTH   = 16,
  parameter int THRESHOLD   = 100
) (
  input  logic                        clk,
  input  logic                        rst_flag_n,
  input  logic                        start,
  input  logic                        valid_in,
  input  logic [16:0]                 clause_idx,
  input  logic [16:0]                 chunk_idx,
  input  logic [CHUNK_WIDTH-1:0]      ta_chunk,
  input  logic [CHUNK_WIDTH-1:0]      lit_chunk,
  output logic                        stop_flag,
  output logic                        clause_out_valid,
  output logic                        clause_out,
  output logic [16:0]                 clause_out_idx,
  output logic signed [SUM_WIDTH-1:0] class_sum,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        busy,
  output logic                        seq_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [16:0] LAST_CLAUSE = 17'(CLAUSES - 1);
  localparam logic [16:0] LAST_CHUNK  = 17'(LA_CHUNKS - 1);

  localparam logic signed [SUM_WIDTH-1:0] ONE   = SUM_WIDTH'(1);
  localparam logic signed [SUM_WIDTH-1:0] T_POS = SUM_WIDTH'(THRESHOLD);
  localparam logic signed [SUM_WIDTH-1:0] T_NEG = -T_POS;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;

  logic [16:0]                 exp_clause_q, exp_clause_d;
  logic [16:0]                 exp_chunk_q,  exp_chunk_d;
  logic                        acc_and_q,    acc_and_d;
  logic                        any_inc_q,    any_inc_d;
  logic signed [SUM_WIDTH-1:0] acc_q,        acc_d;
  logic signed [SUM_WIDTH-1:0] class_sum_q,  class_sum_d;
  logic                        clause_out_valid_q, clause_out_valid_d;
  logic                        clause_out_q,       clause_out_d;
  logic [16:0]                 clause_out_idx_q,   clause_out_idx_d;
  logic                        seq_err_q,          seq_err_d;

  // ---------------------------------------------------------------------------
  // Beat qualification
  // ---------------------------------------------------------------------------
  // start takes priority over any beat arriving in the same cycle. That beat
  // belongs to the pass being abandoned, so it is neither accepted nor flagged.
  logic beat_vld;
  logic in_order;
  logic beat_acc;
  logic beat_bad;
  logic last_chunk;
  logic last_clause;
  logic pass_done;

  always_comb begin
    beat_vld    = (state_q == S_ACCUM) && valid_in && !start;
    in_order    = (clause_idx == exp_clause_q) && (chunk_idx == exp_chunk_q);
    beat_acc    = beat_vld && in_order;
    beat_bad    = beat_vld && !in_order;
    last_chunk  = (exp_chunk_q == LAST_CHUNK);
    last_clause = (exp_clause_q == LAST_CLAUSE);
    pass_done   = beat_acc && last_chunk && last_clause;
  end

  // ---------------------------------------------------------------------------
  // Clause evaluation and voting
  // ---------------------------------------------------------------------------
  // A chunk is satisfied when every included TA sees a 1 literal. A clause
  // also needs at least one include; an empty clause must not vote.
  logic                        chunk_ok;
  logic                        and_upd;
  logic                        inc_upd;
  logic                        clause_bit;
  logic signed [SUM_WIDTH-1:0] vote;
  logic signed [SUM_WIDTH-1:0] acc_next;
  logic signed [SUM_WIDTH-1:0] acc_clamped;

  always_comb begin
    chunk_ok   = &(~ta_chunk | lit_chunk);
    and_upd    = acc_and_q & chunk_ok;
    inc_upd    = any_inc_q | (|ta_chunk);
    clause_bit = and_upd & inc_upd;

    // Even clauses vote for the class and odd clauses vote against it.
    vote = '0;
    if (clause_bit) begin
      vote = exp_clause_q[0] ? -ONE : ONE;
    end
    acc_next = acc_q + vote;

    // The clamp is applied only to the reported sum. The running
    // accumulator stays exact, so intermediate excursions beyond +/-T
    // still cancel correctly.
    if (acc_next > T_POS) begin
      acc_clamped = T_POS;
    end else if (acc_next < T_NEG) begin
      acc_clamped = T_NEG;
    end else begin
      acc_clamped = acc_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_flag_n) begin
    if (!rst_flag_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // In DONE, start wins over a simultaneous accept, so the pending result is dropped.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_ACCUM;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_ACCUM: if (pass_done) state_d = S_DONE;
        S_DONE:  if (result_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // All of these decode the state register, so they are glitch-free and
  // return to their reset values as soon as rst_flag_n falls.
  always_comb begin
    busy         = (state_q == S_ACCUM);
    stop_flag    = (state_q != S_ACCUM);
    result_valid = (state_q == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    exp_clause_d       = exp_clause_q;
    exp_chunk_d        = exp_chunk_q;
    acc_and_d          = acc_and_q;
    any_inc_d          = any_inc_q;
    acc_d              = acc_q;
    class_sum_d        = class_sum_q;
    clause_out_valid_d = 1'b0;
    clause_out_d       = clause_out_q;
    clause_out_idx_d   = clause_out_idx_q;
    seq_err_d          = seq_err_q;

    if (start) begin
      exp_clause_d     = '0;
      exp_chunk_d      = '0;
      acc_and_d        = 1'b1;
      any_inc_d        = 1'b0;
      acc_d            = '0;
      class_sum_d      = '0;
      clause_out_d     = 1'b0;
      clause_out_idx_d = '0;
      seq_err_d        = 1'b0;
    end else begin
      // A dropped beat leaves the expected position untouched, so the
      // stream can recover once the in-order beat arrives.
      if (beat_bad) begin
        seq_err_d = 1'b1;
      end

      if (beat_acc) begin
        if (last_chunk) begin
          clause_out_valid_d = 1'b1;
          clause_out_d       = clause_bit;
          clause_out_idx_d   = exp_clause_q;
          acc_d              = acc_next;
          acc_and_d          = 1'b1;
          any_inc_d          = 1'b0;
          exp_chunk_d        = '0;
          exp_clause_d       = exp_clause_q + 17'd1;
          if (last_clause) begin
            class_sum_d = acc_clamped;
          end
        end else begin
          acc_and_d   = and_upd;
          any_inc_d   = inc_upd;
          exp_chunk_d = exp_chunk_q + 17'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_flag_n) begin
    if (!rst_flag_n) begin
      exp_clause_q       <= '0;
      exp_chunk_q        <= '0;
      acc_and_q          <= 1'b1;
      any_inc_q          <= 1'b0;
      acc_q              <= '0;
      class_sum_q        <= '0;
      clause_out_valid_q <= 1'b0;
      clause_out_q       <= 1'b0;
      clause_out_idx_q   <= '0;
      seq_err_q          <= 1'b0;
    end else begin
      exp_clause_q       <= exp_clause_d;
      exp_chunk_q        <= exp_chunk_d;
      acc_and_q          <= acc_and_d;
      any_inc_q          <= any_inc_d;
      acc_q              <= acc_d;
      class_sum_q        <= class_sum_d;
      clause_out_valid_q <= clause_out_valid_d;
      clause_out_q       <= clause_out_d;
      clause_out_idx_q   <= clause_out_idx_d;
      seq_err_q          <= seq_err_d;
    end
  end

  always_comb begin
    clause_out_valid = clause_out_valid_q;
    clause_out       = clause_out_q;
    clause_out_idx   = clause_out_idx_q;
    class_sum        = class_sum_q;
    seq_err          = seq_err_q;
  end

endmodule

// File: doc/clause_vote_accum.md
# clause_vote_accum

Downstream consumer of the clause/LA-chunk counter and the TA-state ROM. Each beat pairs one 32-bit TA include chunk with the matching 32-bit literal chunk, ANDs chunk-level results into a per-clause output, and accumulates polarity-signed clause votes into a clamped class sum. It drives `stop_flag` back to the counter for throttling, and hands the final sum downstream over a valid/ready handshake.

## Interface
- `CLAUSES`, 2000: clauses per class; even index = positive polarity, odd = negative.
- `LA_CHUNKS`, 49: 32-bit chunks per clause.
- `CHUNK_WIDTH`, 32: bits per TA/literal chunk.
- `SUM_WIDTH`, 16: signed width of the internal accumulator and of `class_sum`.
- `THRESHOLD`, 100: output clamp magnitude T.

- `clk` in 1: rising-edge clock.
- `rst_flag_n` in 1: asynchronous, active-low reset.
- `start` in 1: begins a new inference pass; 1-cycle pulse.
- `valid_in` in 1: beat valid.
- `clause_idx` in 17: clause index of the beat, taken from the counter `clause_count`.
- `chunk_idx` in 17: chunk index of the beat, taken from the counter `la_chunk_count`.
- `ta_chunk` in CHUNK_WIDTH: TA include bits; 1 = include.
- `lit_chunk` in CHUNK_WIDTH: literal bits for the same chunk.
- `stop_flag` out 1: hold request to the counter.
- `clause_out_valid` out 1: 1-cycle strobe, clause result available.
- `clause_out` out 1: clause output bit.
- `clause_out_idx` out 17: index of the clause that produced `clause_out`.
- `class_sum` out SUM_WIDTH: signed clamped vote sum.
- `result_valid` out 1: `class_sum` is valid.
- `result_ready` in 1: downstream accepts the result.
- `busy` out 1: FSM in ACCUM.
- `seq_err` out 1: sticky; cleared by `start` or reset.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- Transitions:
  - IDLE → ACCUM on `start`.
  - ACCUM → DONE after the last beat of the last clause is accepted.
  - DONE → IDLE on `result_valid && result_ready`.
- `start` in any state clears:
  - the accumulator,
  - the expected indices,
  - `seq_err`,
  - the clause registers.
- `start` then enters ACCUM. In DONE it wins over a simultaneous accept, and the result is dropped.
- Expected beat order: chunk 0..LA_CHUNKS-1 within clause, clause 0..CLAUSES-1.
  - A beat whose (`clause_idx`, `chunk_idx`) differs from the expected pair sets `seq_err` and is discarded.
  - Expected indices do not advance on a discarded beat.
- `valid_in` is ignored outside ACCUM.
- Per accepted beat:
  - `acc_and &= &(~ta_chunk | lit_chunk)`
  - `any_inc |= |ta_chunk`
- `acc_and` and `any_inc` reset to 1 and 0 at the start of each clause.
- On the last chunk, with values taken after this beat's update:
  - `clause_out = acc_and & any_inc`. A clause with all TAs excluded outputs 0.
  - Accumulator adds +`clause_out` when the clause index is even, −`clause_out` when it is odd.
  - `clause_out_valid` pulses with `clause_out_idx` set to that clause index.
- Arithmetic: the accumulator is signed SUM_WIDTH with no per-step clamp. It cannot overflow while CLAUSES/2 < 2^(SUM_WIDTH-1).
- `class_sum` = min(max(acc, −T), +T). It is registered on entry to DONE and held until accepted.
- `stop_flag` = 1 in IDLE and DONE, 0 in ACCUM.

## Timing
- Reset values:
  - state IDLE; `stop_flag` 1.
  - `busy`, `clause_out_valid`, `clause_out`, `result_valid`, `seq_err`: 0.
  - `clause_out_idx` 0; `class_sum` 0.
- Reset asserted mid-pass aborts immediately. All outputs go to their reset values asynchronously.
- Throughput: one beat per cycle. A full pass is CLAUSES×LA_CHUNKS accepted beats (98000 at defaults).
- `clause_out_valid` is registered: it is high the cycle after the last-chunk beat is sampled.
- `result_valid`, `class_sum` and `stop_flag`=1 become visible the cycle after the final beat is sampled. The cycle after acceptance, `result_valid` is 0.
- `busy` rises the cycle after `start` and falls with `result_valid` rising.
- The counter may present one further beat in the cycle `stop_flag` rises. That beat lands outside ACCUM and is ignored.

## Test plan
Directed scenarios use CLAUSES=4, LA_CHUNKS=2, T=100.

- **Reset:** hold `rst_flag_n`=0, then release → `stop_flag`=1, `result_valid`=0, `class_sum`=0, `seq_err`=0, `busy`=0.
- **All excluded:** `start`, then 8 in-order beats with `ta_chunk`=0 → 4 `clause_out_valid` pulses, all `clause_out`=0, `class_sum`=0, `result_valid`=1.
- **Mixed votes:**
  - Clause 0 chunk 0: `ta`=0x1, `lit`=0x1.
  - Clause 1 chunk 1: `ta`=0x80000000, `lit`=0x80000000.
  - Clause 2 chunk 0: `ta`=0x3, `lit`=0x1.
  - All other beats: `ta`=0.
  - Expected: `clause_out` = 1,1,0,0; `class_sum`=0. Change clause 2 to `lit`=0x3 → `class_sum`=+1.
- **Clamp:** T=1; clauses 0 and 2 fire, 1 and 3 do not → raw sum +2, `class_sum`=+1.
- **Sequence error:** send (clause 0, chunk 1) first → `seq_err`=1 and the beat is dropped. The in-order stream that follows still completes with the correct sum. The next `start` clears `seq_err`.
- **Handshake, restart, reset:**
  - Hold `result_ready`=0 for 5 cycles → `result_valid`, `class_sum` and `stop_flag`=1 stay stable.
  - `start` together with `result_ready`=1 → ACCUM, `result_valid`=0 next cycle.
  - Assert `rst_flag_n`=0 mid-pass → immediate return to reset values.
